pio_cmd_receiver: RTL

//  FPGA-side end of the HPS->fabric PIO command link for the traffic-light controller.

---
 rtl/pio_cmd_receiver.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pio_cmd_receiver.sv
// Fabric end of the HPS->fabric PIO command link for the traffic-light controller.
// Decodes toggle-framed command words, drives six lamps manually or via a timed 4-phase cycle.
module pio_cmd_receiver #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned DUR_W     = 16,
    parameter int unsigned DEF_DUR_G = 5000,
    parameter int unsigned DEF_DUR_Y = 1000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] cmd_word_i,
    output logic [5:0]  status_o,
    output logic [5:0]  lamp_o
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LAMPS  = 3'd1;
    localparam logic [2:0] OP_TIMING = 3'd2;
    localparam logic [2:0] OP_RUN    = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;

    localparam logic [5:0] LAMP_ALL_RED = 6'b100_100;

    typedef enum logic [1:0] {
        MODE_STOPPED = 2'd0,
        MODE_MANUAL  = 2'd1,
        MODE_AUTO    = 2'd2
    } mode_t;

    // Clamp a 24-bit requested duration into the DUR_W-bit register range; zero becomes one.
    function automatic logic [DUR_W-1:0] sat_dur(input logic [23:0] raw);
        logic [24:0] lim;
        lim = 25'((33'd1 << DUR_W) - 33'd1);
        if (raw == 24'd0)
            sat_dur = DUR_W'(1);
        else if ({1'b0, raw} > lim)
            sat_dur = '1;
        else
            sat_dur = DUR_W'(raw);
    endfunction

    function automatic logic [5:0] phase_lamps(input logic [1:0] ph);
        case (ph)
            2'd0:    phase_lamps = 6'b001_100;
            2'd1:    phase_lamps = 6'b010_100;
            2'd2:    phase_lamps = 6'b100_001;
            default: phase_lamps = 6'b100_010;
        endcase
    endfunction

    logic [31:0]      cmd_p0;
    logic             tog_seen;
    logic             err;
    mode_t            mode;
    logic [1:0]       phase;
    logic [DUR_W-1:0] cnt;
    logic [PRE_W-1:0] presc;
    logic [DUR_W-1:0] dur [4];

    logic             tog_nxt;
    logic             err_nxt;
    mode_t            mode_nxt;
    logic [1:0]       phase_nxt;
    logic [DUR_W-1:0] cnt_nxt;
    logic [PRE_W-1:0] presc_nxt;
    logic [5:0]       lamp_nxt;
    logic             dur_wr;
    logic [1:0]       dur_idx;
    logic [DUR_W-1:0] dur_val;

    logic             new_cmd;
    logic [2:0]       op;
    logic             tick;
    logic [1:0]       phase_inc;

    assign new_cmd   = cmd_p0[31] ^ tog_seen;
    assign op        = cmd_p0[30:28];
    assign tick      = (presc == PRE_LAST);
    assign phase_inc = phase + 2'd1;

    // Stage p0: register the raw PIO word so nothing downstream sees cmd_word_i directly.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            cmd_p0 <= '0;
        else
            cmd_p0 <= cmd_word_i;
    end

    always_comb begin
        tog_nxt   = tog_seen;
        err_nxt   = err;
        mode_nxt  = mode;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        lamp_nxt  = lamp_o;
        presc_nxt = tick ? '0 : presc + 1'b1;
        dur_wr    = 1'b0;
        dur_idx   = cmd_p0[25:24];
        dur_val   = sat_dur(cmd_p0[23:0]);

        if (mode == MODE_AUTO && tick) begin
            if (cnt <= DUR_W'(1)) begin
                phase_nxt = phase_inc;
                cnt_nxt   = dur[phase_inc];
                lamp_nxt  = phase_lamps(phase_inc);
            end else begin
                cnt_nxt = cnt - 1'b1;
            end
        end

        // A command overrides a coincident phase step, except a duration write, which lets it through.
        if (new_cmd) begin
            tog_nxt = cmd_p0[31];
            if (op != OP_TIMING) begin
                phase_nxt = phase;
                cnt_nxt   = cnt;
                lamp_nxt  = lamp_o;
            end
            case (op)
                OP_NOP: err_nxt = 1'b0;
                OP_LAMPS: begin
                    mode_nxt = MODE_MANUAL;
                    lamp_nxt = cmd_p0[5:0];
                end
                OP_TIMING: begin
                    if (cmd_p0[27:26] != 2'b00)
                        err_nxt = 1'b1;
                    else
                        dur_wr = 1'b1;
                end
                OP_RUN: begin
                    mode_nxt  = MODE_AUTO;
                    phase_nxt = 2'd0;
                    cnt_nxt   = dur[0];
                    presc_nxt = '0;
                    lamp_nxt  = phase_lamps(2'd0);
                end
                OP_STOP: begin
                    mode_nxt = MODE_STOPPED;
                    lamp_nxt = LAMP_ALL_RED;
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Stage p1: all architectural state, including lamps, updates on the execute edge.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tog_seen <= 1'b0;
            err      <= 1'b0;
            mode     <= MODE_STOPPED;
            phase    <= 2'd0;
            cnt      <= '0;
            presc    <= '0;
            lamp_o   <= LAMP_ALL_RED;
            dur[0]   <= sat_dur(24'(DEF_DUR_G));
            dur[1]   <= sat_dur(24'(DEF_DUR_Y));
            dur[2]   <= sat_dur(24'(DEF_DUR_G));
            dur[3]   <= sat_dur(24'(DEF_DUR_Y));
        end else begin
            tog_seen <= tog_nxt;
            err      <= err_nxt;
            mode     <= mode_nxt;
            phase    <= phase_nxt;
            cnt      <= cnt_nxt;
            presc    <= presc_nxt;
            lamp_o   <= lamp_nxt;
            if (dur_wr)
                dur[dur_idx] <= dur_val;
        end
    end

    assign status_o = {tog_seen, err, mode == MODE_AUTO, mode == MODE_MANUAL, phase};

endmodule
